// File: rtl/contador_bcd_mux.sv
// Two-digit BCD up/down counter (00-99) with prescaled count rate and a
// time-multiplexed digit output for a 2-digit common-anode display.
module contador_bcd_mux #(
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] valor,
  input  logic       blank_zero,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [1:0] an,
  output logic       fim,
  output logic [3:0] dezenas,
  output logic [3:0] unidades
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          fim_q, fim_d;
  logic          tick;
  logic [3:0]    digit;

  function automatic logic [3:0] sat9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  assign tick = en && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    tens_d  = tens_q;
    units_d = units_q;
    fim_d   = 1'b0;
    if (clr) begin
      presc_d = '0;
      tens_d  = '0;
      units_d = '0;
    end else if (load) begin
      presc_d = '0;
      tens_d  = sat9(valor[7:4]);
      units_d = sat9(valor[3:0]);
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (up) begin
          if (units_q == 4'd9) begin
            units_d = '0;
            if (tens_q == 4'd9) begin
              tens_d = '0;
              fim_d  = 1'b1;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            units_d = units_q + 4'd1;
          end
        end else begin
          if (units_q == 4'd0) begin
            units_d = 4'd9;
            if (tens_q == 4'd0) begin
              tens_d = 4'd9;
              fim_d  = 1'b1;
            end else begin
              tens_d = tens_q - 4'd1;
            end
          end else begin
            units_d = units_q - 4'd1;
          end
        end
      end
    end
  end

  // Scan divider free-runs; only reset affects it.
  always_comb begin
    scan_d = scan_q + 1'b1;
    sel_d  = sel_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      sel_q   <= 1'b0;
      tens_q  <= '0;
      units_q <= '0;
      fim_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      fim_q   <= fim_d;
    end
  end

  // 4'b1111 falls into the decoder's default branch, blanking the digit.
  always_comb begin
    if (sel_q) begin
      an    = 2'b01;
      digit = (blank_zero && (tens_q == 4'd0)) ? 4'b1111 : tens_q;
    end else begin
      an    = 2'b10;
      digit = units_q;
    end
  end

  assign {A, B, C, D} = digit;
  assign fim          = fim_q;
  assign dezenas      = tens_q;
  assign unidades     = units_q;

endmodule
